// File: rtl/dmem_lsu_ctrl_if.sv
// Bundle of CPU-side request/response and word-memory bus signals for dmem_lsu_ctrl.
`timescale 1ns/1ps
interface dmem_lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [3:0]            cpu_read;
  logic [2:0]            cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [31:0]           cpu_writedata;
  logic [31:0]           cpu_readdata;
  logic                  cpu_busywait;
  logic                  cpu_misalign;
  logic [3:0]            mem_read;
  logic [2:0]            mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writedata;
  logic [31:0]           mem_readdata;
  logic                  mem_busywait;

  // Controller view: serves the CPU, masters the memory.
  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata,
    output cpu_readdata, cpu_busywait, cpu_misalign,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_writedata,
    input  cpu_readdata, cpu_busywait, cpu_misalign,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer mapping RV32 byte/half/word accesses onto a word-only memory.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of aligning down.
`timescale 1ns/1ps
module dmem_lsu_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RDATA_RST  = 32'h0
) (
  input logic             clock,
  input logic             reset,
  dmem_lsu_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE, ERR} state_t;

  state_t      state;
  logic [2:0]  funct3_p0;
  logic [1:0]  off_p0;
  logic [31:0] wdata_p0;
  logic        misalign_r;

  logic        ld_v, st_v, req, mis;
  logic [1:0]  sz;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic half, input logic [1:0] off,
                                        input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (half) r[16*off[1] +: 16] = wdata[15:0];
    else      r[8*off +: 8]      = wdata[7:0];
    return r;
  endfunction

  always_comb begin
    ld_v = bus.cpu_read[3] && !bus.cpu_write[2] &&
           (bus.cpu_read[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    st_v = bus.cpu_write[2] && !bus.cpu_read[3] && (bus.cpu_write[1:0] != 2'b11);
    req  = ld_v || st_v;
    sz   = ld_v ? bus.cpu_read[1:0] : bus.cpu_write[1:0];
`ifdef MISALIGN_TRAP_EN
    mis  = ((sz == 2'b01) && bus.cpu_address[0]) ||
           ((sz == 2'b10) && (bus.cpu_address[1:0] != 2'b00));
`else
    mis  = 1'b0;
`endif
  end

  assign bus.cpu_busywait = !reset &&
                            (((state == IDLE) && req) || ((state != IDLE) && (state != DONE)));
  assign bus.cpu_misalign = misalign_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      funct3_p0         <= '0;
      off_p0            <= '0;
      wdata_p0          <= '0;
      misalign_r        <= 1'b0;
      bus.cpu_readdata  <= RDATA_RST;
      bus.mem_read      <= '0;
      bus.mem_write     <= '0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= '0;
    end else begin
      case (state)
        // Accept: latch command so later CPU-side changes cannot disturb the access.
        IDLE: if (req) begin
          funct3_p0       <= ld_v ? bus.cpu_read[2:0] : {1'b0, bus.cpu_write[1:0]};
          off_p0          <= bus.cpu_address[1:0];
          wdata_p0        <= bus.cpu_writedata;
          bus.mem_address <= {bus.cpu_address[ADDR_WIDTH-1:2], 2'b00};
          if (mis) begin
            state      <= ERR;
            misalign_r <= 1'b1;
          end else if (ld_v) begin
            state        <= RD;
            bus.mem_read <= 4'b1010;
          end else if (sz == 2'b10) begin
            state             <= WR;
            bus.mem_write     <= 3'b110;
            bus.mem_writedata <= bus.cpu_writedata;
          end else begin
            state        <= RMW_RD;
            bus.mem_read <= 4'b1010;
          end
        end
        // Memory phase: each state holds until the memory stops stalling.
        RD: if (!bus.mem_busywait) begin
          bus.cpu_readdata <= extract(funct3_p0, off_p0, bus.mem_readdata);
          bus.mem_read     <= '0;
          state            <= DONE;
        end
        RMW_RD: if (!bus.mem_busywait) begin
          bus.mem_read      <= '0;
          bus.mem_write     <= 3'b110;
          bus.mem_writedata <= merge(funct3_p0[0], off_p0, bus.mem_readdata, wdata_p0);
          state             <= RMW_WR;
        end
        WR, RMW_WR: if (!bus.mem_busywait) begin
          bus.mem_write <= '0;
          state         <= DONE;
        end
        ERR: begin
          misalign_r <= 1'b0;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed scoreboard bench for dmem_lsu_ctrl with a word memory model.
`timescale 1ns/1ps
module tb_dmem_lsu_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_lsu_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  dmem_lsu_ctrl #(.ADDR_WIDTH(32), .RDATA_RST(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:15];
  always_comb bus.mem_readdata = mem[bus.mem_address[5:2]];
  always @(posedge clock)
    if (bus.mem_write[2] && !bus.mem_busywait) mem[bus.mem_address[5:2]] <= bus.mem_writedata;

  typedef struct {
    bit          is_load;
    logic [31:0] rdata;
    int          cycles;
    int          edges;
    int          mis;
    int          idx;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int retired  = 0;
  int issued   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: accumulates per-transaction observations and retires on busywait fall.
  int  m_cyc = 0, m_edges = 0, m_ovl = 0, m_mis = 0;
  bit  prev_busy = 0, prev_mr = 0;
  always @(negedge clock) begin
    if (reset) begin
      m_cyc = 0; m_edges = 0; m_ovl = 0; m_mis = 0;
      prev_busy = 0; prev_mr = 0;
    end else begin
      if (bus.cpu_busywait) begin
        m_cyc++;
        if (bus.mem_read[3] && !prev_mr) m_edges++;
        if (bus.mem_read != 4'b0 && bus.mem_write != 3'b0) m_ovl++;
        if (bus.cpu_misalign) m_mis++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          retired++;
          chk("busy_cycles", m_cyc, e.cycles);
          chk("mem_read_edges", m_edges, e.edges);
          chk("rd_wr_overlap", m_ovl, 0);
          chk("misalign_pulses", m_mis, e.mis);
          if (e.is_load) chk("readdata", bus.cpu_readdata, e.rdata);
          else           chk("mem_word", mem[e.idx], e.word);
        end
        m_cyc = 0; m_edges = 0; m_ovl = 0; m_mis = 0;
      end
      prev_busy = bus.cpu_busywait;
      prev_mr   = bus.mem_read[3];
    end
  end

  task automatic issue(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall, input exp_t e);
    int k;
    @(posedge clock); #1;
    sb.push_back(e);
    issued++;
    bus.cpu_read      = rd;
    bus.cpu_write     = wr;
    bus.cpu_address   = addr;
    bus.cpu_writedata = wdata;
    bus.mem_busywait  = (stall > 0);
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == stall + 2) bus.mem_busywait = 1'b0;
    end while (bus.cpu_busywait && k < 60);
    if (k >= 60) chk("retire_timeout", 32'd1, 32'd0);
  endtask

  task automatic no_req(input logic [3:0] rd, input logic [2:0] wr, input string name);
    @(posedge clock); #1;
    bus.cpu_read    = rd;
    bus.cpu_write   = wr;
    bus.cpu_address = 32'h10;
    repeat (2) begin
      @(negedge clock);
      chk(name, {31'b0, bus.cpu_busywait}, 32'd0);
      chk({name, "_mem_read"}, {28'b0, bus.mem_read}, 32'd0);
    end
  endtask

  function automatic exp_t ld(input logic [31:0] rdata, input int cycles, input int edges,
                              input int mis);
    exp_t e;
    e.is_load = 1; e.rdata = rdata; e.cycles = cycles; e.edges = edges;
    e.mis = mis; e.idx = 0; e.word = '0;
    return e;
  endfunction

  function automatic exp_t st(input int idx, input logic [31:0] word, input int cycles,
                              input int edges);
    exp_t e;
    e.is_load = 0; e.rdata = '0; e.cycles = cycles; e.edges = edges;
    e.mis = 0; e.idx = idx; e.word = word;
    return e;
  endfunction

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.cpu_read = '0; bus.cpu_write = '0; bus.cpu_address = '0;
    bus.cpu_writedata = '0; bus.mem_busywait = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_readdata", bus.cpu_readdata, 32'h0);
    chk("rst_mem_read", {28'b0, bus.mem_read}, 32'h0);
    chk("rst_mem_write", {29'b0, bus.mem_write}, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_busywait", {31'b0, bus.cpu_busywait}, 32'h0);
    chk("rst_misalign", {31'b0, bus.cpu_misalign}, 32'h0);
    reset = 1'b0;

    // Reset during RMW_WR aborts the write.
    @(posedge clock); #1;
    bus.cpu_write = 3'b100; bus.cpu_address = 32'h10; bus.cpu_writedata = 32'h77;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.mem_write[2] && k < 10);
    chk("reach_rmw_wr", {29'b0, bus.mem_write}, 32'h6);
    reset = 1'b1;
    #1;
    chk("abort_mem_write", {29'b0, bus.mem_write}, 32'h0);
    chk("abort_busywait", {31'b0, bus.cpu_busywait}, 32'h0);
    bus.cpu_write = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_mem_word", mem[4], 32'h0);
    chk("abort_readdata", bus.cpu_readdata, 32'h0);

    issue(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 0, st(4, 32'hDEADBEEF, 2, 0));
    issue(4'b1010, 3'b000, 32'h10, 32'h0,        0, ld(32'hDEADBEEF, 2, 1, 0));
    issue(4'b0000, 3'b100, 32'h11, 32'h12345680, 0, st(4, 32'hDEAD80EF, 3, 1));
    issue(4'b1000, 3'b000, 32'h11, 32'h0,        0, ld(32'hFFFFFF80, 2, 1, 0));
    issue(4'b1100, 3'b000, 32'h11, 32'h0,        0, ld(32'h00000080, 2, 1, 0));
    issue(4'b0000, 3'b101, 32'h12, 32'hABCD1234, 0, st(4, 32'h123480EF, 3, 1));
    issue(4'b1001, 3'b000, 32'h12, 32'h0,        0, ld(32'h00001234, 2, 1, 0));
    issue(4'b1001, 3'b000, 32'h10, 32'h0,        0, ld(32'hFFFF80EF, 2, 1, 0));
    issue(4'b1101, 3'b000, 32'h10, 32'h0,        0, ld(32'h000080EF, 2, 1, 0));
    issue(4'b1010, 3'b000, 32'h10, 32'h0,        3, ld(32'h123480EF, 5, 1, 0));
    issue(4'b0000, 3'b110, 32'h14, 32'hCAFEF00D, 2, st(5, 32'hCAFEF00D, 4, 0));
`ifdef MISALIGN_TRAP_EN
    issue(4'b1010, 3'b000, 32'h13, 32'h0,        0, ld(32'h123480EF, 2, 0, 1));
`else
    issue(4'b1010, 3'b000, 32'h13, 32'h0,        0, ld(32'h123480EF, 2, 1, 0));
`endif

    no_req(4'b1010, 3'b110, "both_set");
    no_req(4'b1011, 3'b000, "bad_load_f3");
    no_req(4'b0000, 3'b111, "bad_store_f3");
    bus.cpu_read = '0; bus.cpu_write = '0;

    repeat (3) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    chk("retired_count", retired, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
